// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline's IF/MEM stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline and memory together take the master view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data access. Data wins by default;
// a starvation counter forces a fetch grant after STARVE_MAX data grants while fetch waits.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [3:0]  starve_cnt_r, starve_cnt_nxt_s;
    logic        discard_r, discard_nxt_s;
    logic        grant_d_s, grant_i_s;
    logic        m_req_r, m_req_nxt_s;
    logic        m_we_r, m_we_nxt_s;
    logic [31:0] m_addr_r, m_addr_nxt_s;
    logic [31:0] m_wdata_r, m_wdata_nxt_s;
    logic        i_ack_r, i_ack_nxt_s;
    logic [31:0] i_rdata_r, i_rdata_nxt_s;
    logic        d_ack_r, d_ack_nxt_s;
    logic [31:0] d_rdata_r, d_rdata_nxt_s;

    // Grant decision, only meaningful while the bus is free
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.d_req && ((starve_cnt_r < STARVE_LIMIT) || !bus.i_req)) begin
                grant_d_s = 1'b1;
            end else if (bus.i_req && !bus.i_flush) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (!bus.i_req) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (grant_i_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (grant_d_s && (starve_cnt_r < STARVE_LIMIT)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = D_WAIT;
                end else if (grant_i_s) begin
                    state_nxt_s = I_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            I_WAIT, D_WAIT: begin
                if (bus.m_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered bus and ack outputs
    always_comb begin
        m_req_nxt_s   = m_req_r;
        m_we_nxt_s    = m_we_r;
        m_addr_nxt_s  = m_addr_r;
        m_wdata_nxt_s = m_wdata_r;
        i_ack_nxt_s   = 1'b0;
        i_rdata_nxt_s = i_rdata_r;
        d_ack_nxt_s   = 1'b0;
        d_rdata_nxt_s = d_rdata_r;
        discard_nxt_s = discard_r;
        case (state_r)
            IDLE: begin
                discard_nxt_s = 1'b0;
                if (grant_d_s) begin
                    m_req_nxt_s   = 1'b1;
                    m_we_nxt_s    = bus.d_we;
                    m_addr_nxt_s  = bus.d_addr;
                    m_wdata_nxt_s = bus.d_wdata;
                end else if (grant_i_s) begin
                    m_req_nxt_s   = 1'b1;
                    m_we_nxt_s    = 1'b0;
                    m_addr_nxt_s  = bus.i_addr;
                    m_wdata_nxt_s = 32'd0;
                end else begin
                    m_req_nxt_s   = 1'b0;
                end
            end
            I_WAIT: begin
                // A flushed fetch still completes on the bus; only its ack is suppressed
                if (bus.m_ack) begin
                    m_req_nxt_s   = 1'b0;
                    i_ack_nxt_s   = ~(discard_r | bus.i_flush);
                    i_rdata_nxt_s = bus.m_rdata;
                    discard_nxt_s = 1'b0;
                end else if (bus.i_flush) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
            end
            D_WAIT: begin
                if (bus.m_ack) begin
                    m_req_nxt_s   = 1'b0;
                    d_ack_nxt_s   = 1'b1;
                    d_rdata_nxt_s = m_we_r ? 32'd0 : bus.m_rdata;
                end else begin
                    m_req_nxt_s   = m_req_r;
                end
            end
            default: begin
                m_req_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and bookkeeping state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt_r <= 4'd0;
            discard_r    <= 1'b0;
            m_req_r      <= 1'b0;
            m_we_r       <= 1'b0;
            m_addr_r     <= 32'd0;
            m_wdata_r    <= 32'd0;
            i_ack_r      <= 1'b0;
            i_rdata_r    <= 32'd0;
            d_ack_r      <= 1'b0;
            d_rdata_r    <= 32'd0;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
            discard_r    <= discard_nxt_s;
            m_req_r      <= m_req_nxt_s;
            m_we_r       <= m_we_nxt_s;
            m_addr_r     <= m_addr_nxt_s;
            m_wdata_r    <= m_wdata_nxt_s;
            i_ack_r      <= i_ack_nxt_s;
            i_rdata_r    <= i_rdata_nxt_s;
            d_ack_r      <= d_ack_nxt_s;
            d_rdata_r    <= d_rdata_nxt_s;
        end
    end

    assign bus.m_req     = m_req_r;
    assign bus.m_we      = m_we_r;
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wdata   = m_wdata_r;
    assign bus.i_ack     = i_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.stall_if  = bus.i_req & ~i_ack_r;
    assign bus.stall_mem = bus.d_req & ~d_ack_r;
    assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: fetch/data requester agents and a memory agent
// drive the DUT, and a transaction-level reference model predicts every output each cycle.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset_n;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data) plus expected outputs
    int          mdl_owner;
    int          mdl_streak;
    bit          mdl_drop;
    logic        mdl_m_req, mdl_m_we, mdl_i_ack, mdl_d_ack;
    logic [31:0] mdl_m_addr, mdl_m_wdata, mdl_i_rdata, mdl_d_rdata;

    // Agent state and knobs
    bit          f_pend, d_pend, mem_serving, mode_sat;
    int          mem_lat;
    int          p_flush, p_spur, p_rst;
    int          n_iack, n_dack;
    logic        prev_m_req;
    logic [31:0] mem [logic [31:0]];
    bit          grants[$];

    task automatic model_step();
        if (!reset_n) begin
            mdl_owner = 0; mdl_streak = 0; mdl_drop = 1'b0;
            mdl_m_req = 1'b0; mdl_m_we = 1'b0; mdl_i_ack = 1'b0; mdl_d_ack = 1'b0;
            mdl_m_addr = 32'd0; mdl_m_wdata = 32'd0; mdl_i_rdata = 32'd0; mdl_d_rdata = 32'd0;
        end else begin
            mdl_i_ack = 1'b0;
            mdl_d_ack = 1'b0;
            if (mdl_owner == 0) begin
                if (bus.d_req && (mdl_streak < STARVE_MAX || !bus.i_req)) begin
                    mdl_owner = 2; mdl_m_req = 1'b1; mdl_m_we = bus.d_we;
                    mdl_m_addr = bus.d_addr; mdl_m_wdata = bus.d_wdata;
                    if (bus.i_req) mdl_streak = (mdl_streak + 1 > STARVE_MAX) ? STARVE_MAX : mdl_streak + 1;
                end else if (bus.i_req && !bus.i_flush) begin
                    mdl_owner = 1; mdl_m_req = 1'b1; mdl_m_we = 1'b0;
                    mdl_m_addr = bus.i_addr; mdl_m_wdata = 32'd0; mdl_streak = 0;
                end else begin
                    mdl_m_req = 1'b0;
                end
            end else if (mdl_owner == 1) begin
                if (bus.i_flush) mdl_drop = 1'b1;
                if (bus.m_ack) begin
                    mdl_i_ack = !mdl_drop; mdl_i_rdata = bus.m_rdata;
                    mdl_drop = 1'b0; mdl_owner = 0; mdl_m_req = 1'b0;
                end
            end else begin
                if (bus.m_ack) begin
                    mdl_d_ack = 1'b1; mdl_d_rdata = mdl_m_we ? 32'd0 : bus.m_rdata;
                    mdl_owner = 0; mdl_m_req = 1'b0;
                end
            end
            if (!bus.i_req) mdl_streak = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("m_req",   32'(bus.m_req),   32'(mdl_m_req));
        check_eq("m_we",    32'(bus.m_we),    32'(mdl_m_we));
        check_eq("m_addr",  bus.m_addr,       mdl_m_addr);
        check_eq("m_wdata", bus.m_wdata,      mdl_m_wdata);
        check_eq("i_ack",   32'(bus.i_ack),   32'(mdl_i_ack));
        check_eq("i_rdata", bus.i_rdata,      mdl_i_rdata);
        check_eq("d_ack",   32'(bus.d_ack),   32'(mdl_d_ack));
        check_eq("d_rdata", bus.d_rdata,      mdl_d_rdata);
        check_eq("busy",    32'(bus.busy),    32'(mdl_owner != 0));
    endtask

    task automatic drive_inputs();
        logic [31:0] a;
        reset_n = !(p_rst > 0 && $urandom_range(1, p_rst) == 1);
        // fetch agent: holds request until ack, may flush and redirect
        bus.i_flush = 1'b0;
        if (bus.i_ack) f_pend = 1'b0;
        if (f_pend && p_flush > 0 && $urandom_range(1, p_flush) == 1) begin
            bus.i_flush = 1'b1;
            bus.i_addr  = 32'($urandom_range(16'h040, 16'h3FF)) << 2;
        end
        if (!f_pend && (mode_sat || $urandom_range(0, 2) == 0)) begin
            f_pend     = 1'b1;
            bus.i_addr = 32'($urandom_range(16'h040, 16'h3FF)) << 2;
        end
        bus.i_req = f_pend;
        // data agent: loads and stores in a small window so reads hit earlier writes
        if (bus.d_ack) d_pend = 1'b0;
        if (!d_pend && (mode_sat || $urandom_range(0, 2) == 0)) begin
            d_pend      = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = 32'h0000_2000 + (32'($urandom_range(0, 15)) << 2);
            bus.d_wdata = $urandom;
        end
        bus.d_req = d_pend;
        // memory agent: random latency 0..3, occasional spurious ack while idle
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
        if (!bus.m_req) mem_serving = 1'b0;
        if (bus.m_req && !mem_serving) begin
            mem_serving = 1'b1;
            mem_lat     = mode_sat ? 0 : $urandom_range(0, 3);
        end
        if (mem_serving) begin
            if (mem_lat == 0) begin
                bus.m_ack   = 1'b1;
                mem_serving = 1'b0;
                a = bus.m_addr;
                if (bus.m_we) mem[a] = bus.m_wdata;
                else bus.m_rdata = mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
            end else begin
                mem_lat--;
            end
        end else if (!bus.m_req && p_spur > 0 && $urandom_range(1, p_spur) == 1) begin
            bus.m_ack = 1'b1;
        end
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (bus.i_ack) n_iack++;
        if (bus.d_ack) n_dack++;
        if (mode_sat && bus.m_req && !prev_m_req) grants.push_back(bus.m_addr[13]);
        prev_m_req = bus.m_req;
        drive_inputs();
        #1;
        check_eq("stall_if",  32'(bus.stall_if),  32'(bus.i_req & ~mdl_i_ack));
        check_eq("stall_mem", 32'(bus.stall_mem), 32'(bus.d_req & ~mdl_d_ack));
    endtask

    initial begin
        bit exp_d;
        reset_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 32'd0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.m_rdata = 32'd0; bus.m_ack = 1'b0;
        f_pend = 1'b0; d_pend = 1'b0; mem_serving = 1'b0; mem_lat = 0;
        n_iack = 0; n_dack = 0; prev_m_req = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();

        // Both requesters always pending, zero-wait memory: D,D,D,D,I repeating
        mode_sat = 1'b1; p_flush = 0; p_spur = 0; p_rst = 0;
        drive_inputs();
        for (int c = 0; c < 60; c++) run_cycle();
        check_eq("grant_count", 32'(grants.size() >= 20), 32'd1);
        for (int k = 0; k < 20 && k < grants.size(); k++) begin
            exp_d = ((k % 5) != 4);
            check_eq("grant_seq", 32'(grants[k]), 32'(exp_d));
        end

        // Random traffic with flushes, spurious acks and occasional mid-transaction resets
        mode_sat = 1'b0; p_flush = 16; p_spur = 8; p_rst = 150;
        n_iack = 0; n_dack = 0;
        for (int c = 0; c < 3000; c++) run_cycle();
        check_eq("fetch_progress", 32'(n_iack > 50), 32'd1);
        check_eq("data_progress",  32'(n_dack > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
